// File: rtl/maxnet_controller.sv
// rtl/maxnet_controller.sv - Maxnet sequencing controller: load, iterate competition, report winner
//
// Ports:
//   clk, rst_n         system clock (rising edge), asynchronous active-low reset
//   start              begin a run (only honoured while idle)
//   nz_flags           per-neuron "next value > 0" flags, sampled in the check cycle
//   busy               high whenever a run is in progress
//   x_sel, ld_x        input-word select and load strobe for the activation register
//   w_addr             weight address row*N+col, driven while accumulating
//   row_idx            neuron currently being computed
//   clr_acc, mac_en    accumulator clear / multiply-accumulate enables
//   wr_en              write activation(acc) into next-vector slot row_idx
//   commit             copy next-vector into current vector
//   iter               completed iteration count
//   done               one-cycle end-of-run pulse
//   winner/none/timeout run result, held until the next start
module maxnet_controller #(
  parameter int N        = 4,
  parameter int MAX_ITER = 16,
  parameter int AW       = $clog2(N*N),
  parameter int IW       = $clog2(N),
  localparam int ITW     = $clog2(MAX_ITER+1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   nz_flags,
  output logic           busy,
  output logic [IW-1:0]  x_sel,
  output logic           ld_x,
  output logic [AW-1:0]  w_addr,
  output logic [IW-1:0]  row_idx,
  output logic           clr_acc,
  output logic           mac_en,
  output logic           wr_en,
  output logic           commit,
  output logic [ITW-1:0] iter,
  output logic           done,
  output logic [IW-1:0]  winner,
  output logic           none,
  output logic           timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLR, S_MAC, S_WRITE, S_CHECK, S_DONE
  } state_t;

  state_t         state, state_nx;
  logic [IW-1:0]  cnt;        // word index in LOAD, column index in MAC
  logic [IW-1:0]  row;
  logic [ITW-1:0] iter_q;
  logic [ITW-1:0] iter_inc;
  logic [IW-1:0]  winner_q;
  logic           none_q;
  logic           timeout_q;
  logic           cnt_last;
  logic           row_last;
  logic           single_nz;
  logic [IW-1:0]  low_idx;

  assign cnt_last  = (cnt == IW'(N-1));
  assign row_last  = (row == IW'(N-1));
  // At most one bit set: clearing the lowest set bit leaves nothing.
  assign single_nz = ((nz_flags & (nz_flags - N'(1))) == '0);
  // Saturating; the run always terminates at MAX_ITER so this never wraps.
  assign iter_inc  = (iter_q == ITW'(MAX_ITER)) ? iter_q : iter_q + ITW'(1);

  // Lowest set index wins; scanning downward lets the lowest one overwrite.
  always_comb begin
    low_idx = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (nz_flags[i]) low_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  if (cnt_last) state_nx = S_CLR;
      S_CLR:   state_nx = S_MAC;
      S_MAC:   if (cnt_last) state_nx = S_WRITE;
      S_WRITE: state_nx = row_last ? S_CHECK : S_CLR;
      S_CHECK: begin
        if (single_nz || iter_inc == ITW'(MAX_ITER)) state_nx = S_DONE;
        else                                          state_nx = S_CLR;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      row       <= '0;
      iter_q    <= '0;
      winner_q  <= '0;
      none_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt       <= '0;
            row       <= '0;
            iter_q    <= '0;
            winner_q  <= '0;
            none_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        S_LOAD, S_MAC: cnt <= cnt_last ? '0 : cnt + IW'(1);
        S_CLR:         cnt <= '0;
        S_WRITE:       if (!row_last) row <= row + IW'(1);
        S_CHECK: begin
          iter_q <= iter_inc;
          row    <= '0;
          // Results are captured only when the run ends, so they stay
          // stable through DONE and the following idle period.
          if (state_nx == S_DONE) begin
            winner_q  <= low_idx;
            none_q    <= (nz_flags == '0);
            timeout_q <= !single_nz;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign ld_x    = (state == S_LOAD);
  assign x_sel   = (state == S_LOAD) ? cnt : '0;
  assign clr_acc = (state == S_CLR);
  assign mac_en  = (state == S_MAC);
  // N is a power of two, so row*N+col is just the concatenation.
  assign w_addr  = (state == S_MAC) ? AW'({row, cnt}) : '0;
  assign row_idx = row;
  assign wr_en   = (state == S_WRITE);
  assign commit  = (state == S_CHECK);
  assign done    = (state == S_DONE);
  assign iter    = iter_q;
  assign winner  = winner_q;
  assign none    = none_q;
  assign timeout = timeout_q;

endmodule

// File: doc/maxnet_controller.md
# maxnet_controller

Sequencing controller for the Maxnet datapath. It drives the input/weight memory (N input words, N×N weight words) and the shared MAC/activation datapath. It loads the initial activation vector, then runs competition iterations until at most one neuron stays nonzero or an iteration limit is hit. It holds no data itself; it issues addresses, enables and commit strobes, and reports the winner index.

## Interface

Parameters:
- N, 4, number of neurons (power of two, 2..16)
- MAX_ITER, 16, iteration limit before forced termination (≥1)
- AW, $clog2(N*N), weight address width
- IW, $clog2(N), neuron index width

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a run; sampled only in IDLE
- nz_flags  input  N  per-neuron "next value > 0" flags from datapath, valid in CHECK
- busy  output  1  high in every state except IDLE
- x_sel  output  IW  input-word select to memory (LOAD)
- ld_x  output  1  load x_sel word into activation register x_sel
- w_addr  output  AW  weight address = row*N + col
- row_idx  output  IW  neuron currently computed
- clr_acc  output  1  clear accumulator
- mac_en  output  1  accumulate w[w_addr] × x[col]
- wr_en  output  1  write activation(acc) into next-vector slot row_idx
- commit  output  1  copy next-vector into current vector
- iter  output  $clog2(MAX_ITER+1)  completed iteration count
- done  output  1  one-cycle pulse: run finished
- winner  output  IW  index of sole nonzero neuron, valid with done
- none  output  1  with done: zero neurons remain nonzero
- timeout  output  1  with done: MAX_ITER reached with >1 nonzero

## Operation

- States: IDLE, LOAD, CLR, MAC, WRITE, CHECK, DONE.
- IDLE: all strobes low. start=1 → LOAD, clear iter, load counter and flags.
- LOAD: N cycles; ld_x=1, x_sel=0..N-1 in order. After x_sel=N-1 → CLR with row=0.
- CLR: one cycle, clr_acc=1, col reset to 0 → MAC.
- MAC: N cycles, mac_en=1, col=0..N-1, w_addr=row*N+col. After col=N-1 → WRITE.
- WRITE: one cycle, wr_en=1, row_idx=row. If row<N-1, row++ → CLR; else → CHECK.
- CHECK: one cycle, commit=1, nz_flags sampled. Also iter++ (saturating).
  - popcount(nz_flags)≤1 → DONE.
  - otherwise iter (post-increment)==MAX_ITER → DONE with timeout.
  - otherwise → CLR with row=0.
- DONE: one cycle, done=1; winner = lowest set index of sampled flags (0 if none); none=1 iff flags all zero; timeout as decided in CHECK → IDLE.
- winner/none/timeout hold their values until the next start, and are cleared on start.
- start while busy is ignored; it does not restart.
- Counters wrap-free: col and row never exceed N-1; w_addr never exceeds N*N-1.

## Timing

- Reset (rst_n=0, any state, immediate): state=IDLE; all outputs 0, including iter, winner, none, timeout and busy.
- Reset mid-run aborts without done. After release, the block waits for a new start.
- start sampled at edge 0 gives the following schedule:
  - LOAD occupies cycles 1..N.
  - Each iteration takes N·(N+2)+1 cycles.
  - done is high in cycle N + k·(N(N+2)+1) + 1 for k iterations.
  - N=4: 25 cycles per iteration; k=1 gives done in cycle 30.
- busy rises in cycle 1 and falls in the cycle after done.
- All outputs are registered state decodes. No combinational path from start or nz_flags to any output.
- nz_flags must be stable in the CHECK cycle; it reflects the next-vector contents after the final WRITE.

## Test plan

- Reset mid-MAC: assert rst_n=0 during iteration 1, col=2 → all outputs 0 immediately, no done. A later start runs normally from LOAD.
- Single iteration, N=4: nz_flags=4'b0100 in first CHECK → done in cycle 30, winner=2, none=0, timeout=0, iter=1. Across the run, ld_x pulses 4 times, mac_en 16 times, wr_en 4 times and commit once.
- Three iterations: nz_flags=1111, 0110, 0001 in successive CHECKs → done in cycle 80, winner=0, iter=3.
- All-zero result: nz_flags=0000 at first CHECK → done with none=1, winner=0, timeout=0.
- Timeout, MAX_ITER=2: nz_flags always 0011 → done in cycle 55, timeout=1, winner=0, iter=2.
- Address sweep: w_addr over one iteration is exactly 0..15 ascending during mac_en. A start pulse during busy is ignored, and a second start after done clears winner, none and timeout.
